// File: rtl/serial_subtractor.sv
// ----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor: d = (a - b - bin) mod 2^WIDTH, one bit
//   per clock, LSB first, with a start/busy/done handshake. Companion to the
//   ripple-carry adder; trades latency (WIDTH+1 cycles per result) for area.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   request, sampled only in IDLE or DONE
//   a      in   [WIDTH-1:0] minuend, captured on accepted start
//   b      in   [WIDTH-1:0] subtrahend, captured on accepted start
//   bin    in   borrow-in, captured on accepted start
//   busy   out  high while in RUN
//   done   out  one-cycle pulse when d/bo are updated
//   d      out  [WIDTH-1:0] difference, held until the next completion
//   bo     out  borrow-out, held until the next completion
//   ovf    out  signed overflow, held like d (only with SERIAL_SUB_OVF_EN)
//
// Build option: define SERIAL_SUB_OVF_EN to add the ovf output.
// ----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
`ifdef SERIAL_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             bo
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bo_q, bo_d;
`ifdef SERIAL_SUB_OVF_EN
    // Operand sign bits are kept aside because ra/rb are shifted away.
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic             ovf_q, ovf_d;
`endif

    logic accept;
    logic last_bit;
    logic x, y, diff_bit, borrow_nxt;

    assign accept   = (state_q != RUN) && start;
    assign last_bit = (state_q == RUN) && (cnt_q == CNT_LAST);

    // One full-subtractor slice on the current LSBs.
    always_comb begin
        x          = ra_q[0];
        y          = rb_q[0];
        diff_bit   = x ^ y ^ br_q;
        borrow_nxt = (~x & y) | (~(x ^ y) & br_q);
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? RUN : IDLE;
            RUN:     state_d = last_bit ? DONE : RUN;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_comb begin
        ra_d  = ra_q;
        rb_d  = rb_q;
        sr_d  = sr_q;
        br_d  = br_q;
        cnt_d = cnt_q;
        d_d   = d_q;
        bo_d  = bo_q;
`ifdef SERIAL_SUB_OVF_EN
        sa_d  = sa_q;
        sb_d  = sb_q;
        ovf_d = ovf_q;
`endif
        if (accept) begin
            ra_d  = a;
            rb_d  = b;
            br_d  = bin;
            sr_d  = '0;
            cnt_d = '0;
`ifdef SERIAL_SUB_OVF_EN
            sa_d  = a[WIDTH-1];
            sb_d  = b[WIDTH-1];
`endif
        end else if (state_q == RUN) begin
            ra_d  = {1'b0, ra_q[WIDTH-1:1]};
            rb_d  = {1'b0, rb_q[WIDTH-1:1]};
            sr_d  = {diff_bit, sr_q[WIDTH-1:1]};
            br_d  = borrow_nxt;
            cnt_d = cnt_q + 1'b1;
            if (last_bit) begin
                // The final diff bit is the result MSB, so load d from the
                // shifted value rather than waiting a cycle for sr_q.
                d_d  = {diff_bit, sr_q[WIDTH-1:1]};
                bo_d = borrow_nxt;
`ifdef SERIAL_SUB_OVF_EN
                ovf_d = (sa_q ^ sb_q) & (diff_bit ^ sa_q);
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra_q  <= '0;
            rb_q  <= '0;
            sr_q  <= '0;
            br_q  <= 1'b0;
            cnt_q <= '0;
            d_q   <= '0;
            bo_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            sa_q  <= 1'b0;
            sb_q  <= 1'b0;
            ovf_q <= 1'b0;
`endif
        end else begin
            ra_q  <= ra_d;
            rb_q  <= rb_d;
            sr_q  <= sr_d;
            br_q  <= br_d;
            cnt_q <= cnt_d;
            d_q   <= d_d;
            bo_q  <= bo_d;
`ifdef SERIAL_SUB_OVF_EN
            sa_q  <= sa_d;
            sb_q  <= sb_d;
            ovf_q <= ovf_d;
`endif
        end
    end

    assign d  = d_q;
    assign bo = bo_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf = ovf_q;
`endif

endmodule
